// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state type and digit-count helper for the digit-serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// rtl/sub_digit.sv - combinational DIGIT-bit borrow subtractor: {bout, diff} = a - b - bin
module sub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT:0] full;

  // One extra bit catches the borrow as the sign of the widened difference
  assign full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign diff = full[DIGIT-1:0];
  assign bout = full[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// rtl/digit_serial_subtractor.sv - multi-cycle a - b - bin, LSB digit first, registered borrow chain
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $fatal(1, "digit_serial_subtractor: illegal WIDTH/DIGIT combination");
  end

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = $clog2(NDIG + 1);

  sub_state_t             state;
  logic [WIDTH-1:0]       sa;
  logic [WIDTH-1:0]       sb;
  logic [WIDTH-1:0]       res;
  logic                   borrow;
  logic                   a_msb;
  logic                   b_msb;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       d;
  logic                   bnext;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last;
  logic                   accept;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (sa[DIGIT-1:0]),
    .b    (sb[DIGIT-1:0]),
    .bin  (borrow),
    .diff (d),
    .bout (bnext)
  );

  // Concatenate-then-slice keeps the shift legal even when DIGIT == WIDTH
  assign res_cat  = {d, res};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt == CW'(NDIG - 1));
  assign accept   = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          sa     <= sa >> DIGIT;
          sb     <= sb >> DIGIT;
          res    <= res_next;
          borrow <= bnext;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bout  <= bnext;
            zero  <= (res_next == '0);
            // Sign bits were captured at start since the operand registers shift them out
            ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
          end
        end
        default: begin
          if (accept) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb/tb_digit_serial_subtractor.sv - scoreboard bench for digit_serial_subtractor (W8/D2 plus W16 sweep)
module tb_digit_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;
  exp_t q[4][$];

  logic       start0, bin0, busy0, done0, bout0, zero0, ovf0;
  logic [7:0] a0, b0, diff0;

  logic        startw, binw;
  logic [15:0] aw, bw;
  logic [2:0]  busyw, donew, boutw, zerow, ovfw;
  logic [15:0] diffw [3];

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .bin(bin0),
    .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .zero(zero0), .ovf(ovf0)
  );

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(startw), .a(aw), .b(bw), .bin(binw),
    .busy(busyw[0]), .done(donew[0]), .diff(diffw[0]), .bout(boutw[0]), .zero(zerow[0]), .ovf(ovfw[0])
  );

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(startw), .a(aw), .b(bw), .bin(binw),
    .busy(busyw[1]), .done(donew[1]), .diff(diffw[1]), .bout(boutw[1]), .zero(zerow[1]), .ovf(ovfw[1])
  );

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(startw), .a(aw), .b(bw), .bin(binw),
    .busy(busyw[2]), .done(donew[2]), .diff(diffw[2]), .bout(boutw[2]), .zero(zerow[2]), .ovf(ovfw[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin, input int due);
    exp_t        e;
    int          t;
    logic [15:0] m;
    m      = (w == 16) ? 16'hFFFF : 16'h00FF;
    t      = int'({16'h0, a & m}) - int'({16'h0, b & m}) - int'({31'h0, bin});
    e.diff = 16'(t) & m;
    e.bout = (t < 0);
    e.zero = (e.diff == 16'h0);
    e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
    e.cyc  = due;
    return e;
  endfunction

  function automatic int qtotal();
    return q[0].size() + q[1].size() + q[2].size() + q[3].size();
  endfunction

  task automatic mon(input int id, input logic dn, input logic [15:0] d,
                     input logic bo, input logic z, input logic o);
    exp_t e;
    if (dn) begin
      chk($sformatf("dut%0d_done_expected", id), 32'(q[id].size() > 0), 32'd1);
      if (q[id].size() > 0) begin
        e = q[id].pop_front();
        chk($sformatf("dut%0d_diff", id), {16'h0, d}, {16'h0, e.diff});
        chk($sformatf("dut%0d_bout", id), {31'h0, bo}, {31'h0, e.bout});
        chk($sformatf("dut%0d_zero", id), {31'h0, z}, {31'h0, e.zero});
        chk($sformatf("dut%0d_ovf", id), {31'h0, o}, {31'h0, e.ovf});
        chk($sformatf("dut%0d_done_cycle", id), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, {8'h0, diff0}, bout0, zero0, ovf0);
    for (int k = 0; k < 3; k++) mon(k + 1, donew[k], diffw[k], boutw[k], zerow[k], ovfw[k]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int bcnt, input bit do_hold, input logic [7:0] hold);
    int n;
    n    = 0;
    bcnt = 0;
    while (qtotal() != 0 && n < 60) begin
      bcnt += int'(busy0);
      if (do_hold && busy0) chk("hold_diff", {24'h0, diff0}, {24'h0, hold});
      step();
      n++;
    end
    chk("drain_timeout", qtotal(), 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input bit do_hold, input logic [7:0] hold, output int bcnt);
    a0     = a;
    b0     = b;
    bin0   = bin;
    start0 = 1'b1;
    q[0].push_back(model(8, {8'h0, a}, {8'h0, b}, bin, cyc + 5));
    step();
    start0 = 1'b0;
    drain(bcnt, do_hold, hold);
  endtask

  initial begin
    int bc;
    rst_n  = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; bin0 = 1'b0;
    startw = 1'b0; aw = '0; bw = '0; binw = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {19'h0, busy0, done0, diff0, bout0, zero0, ovf0}, 32'h0);
    #3 rst_n = 1'b1;
    step();

    run_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h00, bc);
    chk("busy_cycles", bc, 4);
    run_op(8'h08, 8'h0C, 1'b0, 1'b1, 8'h02, bc);
    run_op(8'h00, 8'h00, 1'b1, 1'b1, 8'hFC, bc);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, bc);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h00, bc);
    run_op(8'h7F, 8'hFF, 1'b1, 1'b1, 8'h7F, bc);
    chk("busy_cycles_last", bc, 4);

    // start pulsed mid-RUN with different operands must be ignored
    a0 = 8'h10; b0 = 8'h01; bin0 = 1'b0; start0 = 1'b1;
    q[0].push_back(model(8, 16'h0010, 16'h0001, 1'b0, cyc + 5));
    step();
    start0 = 1'b0;
    step();
    a0 = 8'h33; b0 = 8'h44; bin0 = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    drain(bc, 1'b0, 8'h00);

    // start held through DONE: back-to-back, second done 5 cycles after the first
    a0 = 8'h21; b0 = 8'h12; bin0 = 1'b0; start0 = 1'b1;
    q[0].push_back(model(8, 16'h0021, 16'h0012, 1'b0, cyc + 5));
    step();
    a0 = 8'h01; b0 = 8'h02; bin0 = 1'b1;
    q[0].push_back(model(8, 16'h0001, 16'h0002, 1'b1, cyc + 9));
    repeat (5) step();
    start0 = 1'b0;
    drain(bc, 1'b0, 8'h00);

    // asynchronous reset during RUN cycle 2 aborts with no done
    a0 = 8'h55; b0 = 8'h11; bin0 = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {19'h0, busy0, done0, diff0, bout0, zero0, ovf0}, 32'h0);
    repeat (3) step();
    chk("idle_after_reset", {31'h0, busy0}, 32'h0);
    #3 rst_n = 1'b1;
    step();
    run_op(8'h9A, 8'h3C, 1'b1, 1'b1, 8'h00, bc);
    chk("busy_cycles_after_reset", bc, 4);

    for (int i = 0; i < 200; i++) begin
      aw     = 16'($urandom);
      bw     = 16'($urandom);
      binw   = 1'($urandom);
      startw = 1'b1;
      q[1].push_back(model(16, aw, bw, binw, cyc + 17));
      q[2].push_back(model(16, aw, bw, binw, cyc + 5));
      q[3].push_back(model(16, aw, bw, binw, cyc + 2));
      step();
      startw = 1'b0;
      drain(bc, 1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
